// File: rtl/mmio_periph_pkg.sv
// Shared register map, bit positions and bus-lane helpers for mmio_periph.
package mmio_periph_pkg;

   // Word offsets within the 8-word window (address bits [4:2]).
   typedef enum logic [2:0] {
      OFF_ZERO    = 3'd0,
      OFF_CTRL    = 3'd1,
      OFF_STATUS  = 3'd2,
      OFF_CMP     = 3'd3,
      OFF_DUTY_HI = 3'd4,
      OFF_MICROS  = 3'd5,
      OFF_MILLIS  = 3'd6,
      OFF_DUTY_LO = 3'd7
   } reg_off_e;

   localparam int CTRL_IE      = 0;
   localparam int CTRL_CLR     = 1;
   localparam int STATUS_MATCH = 0;

   // funct3 size bits: word wins over half, neither means byte.
   localparam int F3_HALF = 0;
   localparam int F3_WORD = 1;

   localparam int DUTY_W    = 8;
   localparam int US_PER_MS = 1000;

   // Lanes touched by a store of the given size at the given byte offset.
   function automatic logic [3:0] byte_en(input logic [1:0] f3, input logic [1:0] a);
      if (f3[F3_WORD])      return 4'hF;
      else if (f3[F3_HALF]) return a[1] ? 4'hC : 4'h3;
      else                  return 4'b0001 << a;
   endfunction

   // Replicate right-aligned store data across lanes so any enabled lane sees its bytes.
   function automatic logic [31:0] align_wdata(input logic [1:0] f3, input logic [31:0] d);
      if (f3[F3_WORD])      return d;
      else if (f3[F3_HALF]) return {2{d[15:0]}};
      else                  return {4{d[7:0]}};
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: bus-written shadow duty, period-aligned active duty, compare.
module pwm_channel
   import mmio_periph_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [DUTY_W-1:0] wdata,
   input  logic [DUTY_W-1:0] cnt,
   input  logic              wrap,
   output logic [DUTY_W-1:0] shadow,
   output logic              pwm
);

   logic [DUTY_W-1:0] active;

   // Shadow takes bus writes any time; active only changes at the period boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         active <= '0;
      end else begin
         if (we)   shadow <= wdata;
         if (wrap) active <= shadow;
      end
   end

   // Driven straight from flops, so an async reset drops the output immediately.
   assign pwm = (cnt < active);

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped peripheral: PWM bank, coherent us/ms timers, compare interrupt.
module mmio_periph
   import mmio_periph_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 12000000,
   parameter int unsigned NUM_PWM   = 4,
   parameter int unsigned PWM_DIV   = 1,
   parameter logic [31:0] BASE_ADDR = 32'hFFFFFFE0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               write_mem,
   input  logic [2:0]         funct3,
   input  logic [31:0]        write_address,
   input  logic [31:0]        write_data,
   input  logic [31:0]        read_address,
   output logic [31:0]        read_data,
   output logic               read_hit,
   output logic [NUM_PWM-1:0] pwm_out,
   output logic               irq
);

   localparam int unsigned PRE   = CLK_HZ / 1000000;
   localparam int          PRE_W = (PRE > 1) ? $clog2(PRE) : 1;
   localparam int          DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   // ---------------- write decode ----------------
   logic        wr_hit;
   reg_off_e    woff;
   logic [3:0]  be;
   logic [31:0] wword;
   logic        ctrl_we, clr, w1c;

   assign wr_hit  = write_mem && (write_address[31:5] == BASE_ADDR[31:5]);
   assign woff    = reg_off_e'(write_address[4:2]);
   assign be      = byte_en(funct3[1:0], write_address[1:0]);
   assign wword   = align_wdata(funct3[1:0], write_data);
   assign ctrl_we = wr_hit && (woff == OFF_CTRL) && be[0];
   assign clr     = ctrl_we && wword[CTRL_CLR];
   assign w1c     = wr_hit && (woff == OFF_STATUS) && be[0] && wword[STATUS_MATCH];

   // ---------------- timers ----------------
   logic [PRE_W-1:0] pre;
   logic [9:0]       ms_sub;
   logic [31:0]      micros, millis;
   logic             tick;

   assign tick = !clr && (pre == PRE_W'(PRE - 1));

   // Prescaler -> MICROS, and a 0..999 micro-tick counter -> MILLIS, so both move together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre    <= '0;
         ms_sub <= '0;
         micros <= '0;
         millis <= '0;
      end else if (clr) begin
         pre    <= '0;
         ms_sub <= '0;
         micros <= '0;
         millis <= '0;
      end else if (tick) begin
         pre    <= '0;
         micros <= micros + 32'd1;
         if (ms_sub == 10'(US_PER_MS - 1)) begin
            ms_sub <= '0;
            millis <= millis + 32'd1;
         end else begin
            ms_sub <= ms_sub + 10'd1;
         end
      end else begin
         pre <= pre + 1'b1;
      end
   end

   // ---------------- compare / control ----------------
   logic [31:0] cmp;
   logic        ie, match, match_set;

   // Only a micro-tick can raise MATCH; rewriting CMP never does.
   assign match_set = tick && ((micros + 32'd1) == cmp);

   // CMP/CTRL storage, MATCH with set-over-clear priority, and registered irq.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp   <= '0;
         ie    <= 1'b0;
         match <= 1'b0;
         irq   <= 1'b0;
      end else begin
         if (wr_hit && (woff == OFF_CMP)) begin
            for (int k = 0; k < 4; k++)
               if (be[k]) cmp[8*k +: 8] <= wword[8*k +: 8];
         end
         if (ctrl_we) ie <= wword[CTRL_IE];
         match <= match_set | (match & ~w1c);
         irq   <= match & ie;
      end
   end

   // ---------------- PWM ----------------
   logic [DIV_W-1:0] div;
   logic [7:0]       pcnt;
   logic             step, wrap;

   assign step = (div == DIV_W'(PWM_DIV - 1));
   assign wrap = step && (pcnt == 8'hFF);

   // Shared period counter, advancing once every PWM_DIV clocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div  <= '0;
         pcnt <= '0;
      end else if (step) begin
         div  <= '0;
         pcnt <= pcnt + 8'd1;
      end else begin
         div <= div + 1'b1;
      end
   end

   logic [NUM_PWM-1:0][7:0] shadow;

   for (genvar i = 0; i < NUM_PWM; i++) begin : g_ch
      localparam reg_off_e CH_OFF = (i < 4) ? OFF_DUTY_LO : OFF_DUTY_HI;
      pwm_channel u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .we     (wr_hit && (woff == CH_OFF) && be[i % 4]),
         .wdata  (wword[8*(i % 4) +: 8]),
         .cnt    (pcnt),
         .wrap   (wrap),
         .shadow (shadow[i]),
         .pwm    (pwm_out[i])
      );
   end

   // ---------------- read path ----------------
   logic [7:0][7:0] duty_all;
   logic            rd_in;
   logic [31:0]     rword;

   // Absent channels read as zero bytes.
   always_comb begin
      duty_all = '0;
      for (int i = 0; i < NUM_PWM; i++) duty_all[i] = shadow[i];
   end

   assign rd_in = (read_address[31:5] == BASE_ADDR[31:5]);

   // Word select; reads see register values from before any same-edge write.
   always_comb begin
      rword = '0;
      case (reg_off_e'(read_address[4:2]))
         OFF_DUTY_LO: rword = duty_all[3:0];
         OFF_MILLIS:  rword = millis;
         OFF_MICROS:  rword = micros;
         OFF_DUTY_HI: rword = duty_all[7:4];
         OFF_CMP:     rword = cmp;
         OFF_STATUS:  rword = {31'b0, match};
         OFF_CTRL:    rword = {31'b0, ie};
         default:     rword = '0;
      endcase
   end

   // One-cycle registered read response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data <= '0;
         read_hit  <= 1'b0;
      end else begin
         read_data <= rd_in ? rword : 32'd0;
         read_hit  <= rd_in;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{funct3[2], read_address[1:0]};

endmodule

// File: tb/tb_mmio_periph.sv
// Scoreboard bench for mmio_periph with a cycle-count based reference model.
module tb_mmio_periph;

   localparam int unsigned CLK_HZ  = 12000000;
   localparam int unsigned NUM_PWM = 6;
   localparam int unsigned PWM_DIV = 2;
   localparam int unsigned PRE     = CLK_HZ / 1000000;
   localparam logic [31:0] BASE    = 32'hFFFFFFE0;

   logic               clk = 1'b0, rst_n = 1'b0, write_mem = 1'b0;
   logic [2:0]         funct3 = '0;
   logic [31:0]        write_address = '0, write_data = '0, read_address = '0;
   logic [31:0]        read_data;
   logic               read_hit, irq;
   logic [NUM_PWM-1:0] pwm_out;

   always #5 clk = ~clk;

   mmio_periph #(.CLK_HZ(CLK_HZ), .NUM_PWM(NUM_PWM), .PWM_DIV(PWM_DIV), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .write_mem(write_mem), .funct3(funct3),
      .write_address(write_address), .write_data(write_data), .read_address(read_address),
      .read_data(read_data), .read_hit(read_hit), .pwm_out(pwm_out), .irq(irq)
   );

   typedef struct {
      longint             due;
      bit                 rd;
      logic               hit;
      logic [31:0]        data;
      logic [NUM_PWM-1:0] pwm;
      logic               irq;
   } exp_t;

   exp_t   sb[$];
   int     checks = 0, passes = 0;
   longint cyc = 0;
   bit     rd_chk = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: timers as edges-since-clear, PWM counter as edges-since-reset.
   longint      m_tcnt = 0, m_pcnt = 0;
   logic [7:0]  m_sh[8], m_act[8];
   logic [31:0] m_cmp = 0;
   logic        m_ie = 0, m_match = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic bound_fail(input string name);
      checks++;
      $display("FAIL %s: got timeout want event (t=%0t)", name, $time);
   endtask

   function automatic logic [31:0] cur_us();
      return 32'(m_tcnt / PRE);
   endfunction

   function automatic int cur_cnt();
      return int'((m_pcnt / PWM_DIV) % 256);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a[31:5] != BASE[31:5]) return 32'd0;
      case (a[4:2])
         3'd7:    return {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
         3'd6:    return 32'(m_tcnt / PRE / 1000);
         3'd5:    return cur_us();
         3'd4:    return {m_sh[7], m_sh[6], m_sh[5], m_sh[4]};
         3'd3:    return m_cmp;
         3'd2:    return {31'b0, m_match};
         3'd1:    return {31'b0, m_ie};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_tcnt = 0; m_pcnt = 0; m_cmp = 0; m_ie = 0; m_match = 0;
      for (int k = 0; k < 8; k++) begin m_sh[k] = 8'h00; m_act[k] = 8'h00; end
      sb.delete();
   endtask

   // Predict the effect of the coming posedge given the inputs just driven.
   task automatic model_step();
      exp_t        e;
      logic [3:0]  en;
      logic [7:0]  wb[4];
      logic        om, oie;
      logic [31:0] ocmp;
      bit          clr, w1c, set;
      int          cnt;
      e.due  = cyc + 1;
      e.rd   = rd_chk;
      e.hit  = (read_address[31:5] == BASE[31:5]);
      e.data = m_read(read_address);
      om = m_match; oie = m_ie; ocmp = m_cmp; clr = 0; w1c = 0;
      m_pcnt++;
      cnt = cur_cnt();
      if ((m_pcnt % PWM_DIV) == 0 && cnt == 0)
         for (int k = 0; k < 8; k++) m_act[k] = m_sh[k];
      if (write_mem && write_address[31:5] == BASE[31:5]) begin
         for (int k = 0; k < 4; k++) begin
            en[k] = funct3[1] ? 1'b1 : funct3[0] ? (int'(write_address[1]) == k / 2) : (int'(write_address[1:0]) == k);
            wb[k] = funct3[1] ? write_data[8*k +: 8] : funct3[0] ? write_data[8*(k%2) +: 8] : write_data[7:0];
         end
         case (write_address[4:2])
            3'd7: for (int k = 0; k < 4; k++) if (en[k] && k < NUM_PWM) m_sh[k] = wb[k];
            3'd4: for (int k = 0; k < 4; k++) if (en[k] && k + 4 < NUM_PWM) m_sh[k+4] = wb[k];
            3'd3: for (int k = 0; k < 4; k++) if (en[k]) m_cmp[8*k +: 8] = wb[k];
            3'd2: w1c = en[0] && wb[0][0];
            3'd1: if (en[0]) begin m_ie = wb[0][0]; clr = wb[0][1]; end
            default: ;
         endcase
      end
      if (clr) m_tcnt = 0;
      else     m_tcnt++;
      set = !clr && (m_tcnt % PRE) == 0 && cur_us() == ocmp;
      if (w1c) m_match = 0;
      if (set) m_match = 1;
      for (int i = 0; i < NUM_PWM; i++) e.pwm[i] = (cnt < int'(m_act[i]));
      e.irq = om & oie;
      sb.push_back(e);
   endtask

   // Monitor: compare each due expectation away from the active edge.
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n) begin
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.due < cyc) bound_fail("stale_expectation");
            else begin
               chk("pwm_out", 32'(pwm_out), 32'(mon_e.pwm));
               chk("irq", 32'(irq), 32'(mon_e.irq));
               if (mon_e.rd) begin
                  chk("read_hit", 32'(read_hit), 32'(mon_e.hit));
                  chk("read_data", read_data, mon_e.data);
               end
            end
         end
      end
   end

   task automatic drive(input logic w, input logic [2:0] f, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [31:0] ra, input bit rc);
      @(negedge clk);
      write_mem = w; funct3 = f; write_address = wa; write_data = wd; read_address = ra; rd_chk = rc;
      model_step();
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic rd(input logic [31:0] a);
      drive(1'b0, 3'd0, 32'd0, 32'd0, a, 1'b1);
   endtask

   task automatic wr(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, f, a, d, 32'd0, 1'b0);
   endtask

   task automatic release_reset();
      repeat (2) @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      write_mem = 0; funct3 = 0; write_address = 0; write_data = 0; read_address = 0; rd_chk = 0;
      model_step();
   endtask

   task automatic wait_match(input string name, input int limit);
      int i;
      for (i = 0; i < limit && !m_match; i++) idle(1);
      if (!m_match) bound_fail(name);
   endtask

   task automatic wait_cnt(input string name, input int target);
      int i;
      for (i = 0; i < 1200 && cur_cnt() != target; i++) idle(1);
      if (cur_cnt() != target) bound_fail(name);
   endtask

   initial begin
      logic [31:0] a;
      int          i;
      model_reset();
      #12;
      chk("rst_pwm", 32'(pwm_out), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_read_hit", 32'(read_hit), 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      release_reset();

      rd(32'hFFFFFFFC);
      rd(32'h00001000);
      rd(32'hFFFFFFF4);

      // Mid-period byte write to channel 2; output must wait for the wrap.
      wait_cnt("wait_cnt_40", 8'h40);
      wr(3'b000, 32'hFFFFFFFE, 32'h00000080);
      rd(32'hFFFFFFFC);
      idle(1100);
      rd(32'hFFFFFFFC);

      // Timers near 12000 clocks, then clear.
      for (i = 0; i < 20000 && m_tcnt < 12000; i++) idle(1);
      rd(32'hFFFFFFF4);
      rd(32'hFFFFFFF8);
      drive(1'b1, 3'b010, 32'hFFFFFFE4, 32'h2, 32'hFFFFFFF4, 1'b1);
      rd(32'hFFFFFFF4);
      rd(32'hFFFFFFF8);
      idle(30);
      rd(32'hFFFFFFF4);
      rd(32'hFFFFFFE4);

      // Compare match with interrupt enabled, then W1C.
      wr(3'b010, 32'hFFFFFFEC, 32'd50);
      wr(3'b010, 32'hFFFFFFE4, 32'h1);
      wait_match("wait_match_50", 1000);
      idle(3);
      rd(32'hFFFFFFE8);
      wr(3'b010, 32'hFFFFFFE8, 32'h1);
      idle(2);
      rd(32'hFFFFFFE8);

      // Rewriting CMP to the current count must not raise MATCH.
      wr(3'b010, 32'hFFFFFFEC, cur_us());
      idle(30);
      rd(32'hFFFFFFE8);

      // W1C landing on the same edge as a fresh match: set wins.
      wr(3'b010, 32'hFFFFFFEC, cur_us() + 3);
      wait_match("wait_match_a", 200);
      idle(2);
      wr(3'b010, 32'hFFFFFFEC, cur_us() + 3);
      for (i = 0; i < 200 && !(((m_tcnt + 1) % PRE) == 0 && 32'((m_tcnt + 1) / PRE) == m_cmp); i++) idle(1);
      if (i >= 200) bound_fail("wait_match_edge");
      wr(3'b010, 32'hFFFFFFE8, 32'h1);
      idle(3);
      rd(32'hFFFFFFE8);

      // Half/word writes, missing channels, read-only words.
      wr(3'b001, 32'hFFFFFFF2, 32'h0000BEEF);
      rd(32'hFFFFFFF0);
      wr(3'b001, 32'hFFFFFFF0, 32'h00001234);
      rd(32'hFFFFFFF0);
      wr(3'b010, 32'hFFFFFFFC, 32'h11223344);
      rd(32'hFFFFFFFC);
      wr(3'b010, 32'hFFFFFFF8, 32'hDEADBEEF);
      rd(32'hFFFFFFF8);
      wr(3'b000, 32'hFFFFFFE1, 32'hFF);
      rd(32'hFFFFFFE0);

      // Randomised traffic, mostly inside the window.
      for (int n = 0; n < 400; n++) begin
         a = ($urandom_range(0, 9) == 0) ? $urandom : {BASE[31:5], 5'($urandom)};
         drive(1'($urandom), 3'($urandom), a, $urandom,
               ($urandom_range(0, 7) == 0) ? $urandom : {BASE[31:5], 5'($urandom)}, 1'b1);
      end
      idle(600);

      // Async reset mid-period with full duty on channel 0.
      wr(3'b000, 32'hFFFFFFFC, 32'hFF);
      idle(600);
      wait_cnt("wait_cnt_80", 8'h80);
      chk("pre_rst_pwm0", 32'(pwm_out[0]), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_pwm", 32'(pwm_out), 32'd0);
      chk("async_irq", 32'(irq), 32'd0);
      chk("async_read_hit", 32'(read_hit), 32'd0);
      chk("async_read_data", read_data, 32'd0);
      release_reset();
      for (int k = 0; k < 8; k++) rd(BASE + 32'(4 * k));
      idle(3);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
